// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl_if
// Brief    : Value/strobe inputs and display outputs of the 7-segment scanner.
// Revision : 1.0
// ============================================================================
interface seg7_scan_ctrl_if #(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 4
);
    logic [DATA_W-1:0]     data;
    logic                  data_valid;
    logic                  is_signed;
    logic                  display_mode;
    logic                  busy;
    logic                  overflow;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] an;

    modport master (
        output data, data_valid, is_signed, display_mode,
        input  busy, overflow, seg, an
    );

    modport slave (
        input  data, data_valid, is_signed, display_mode,
        output busy, overflow, seg, an
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : Signed/unsigned value to multiplexed 7-segment display, decimal
//            (iterative double-dabble) or hex; SEG7_LZ_BLANK_EN blanks zeros.
// Revision : 1.0
// ============================================================================
module seg7_scan_ctrl #(
    parameter int DATA_W       = 8,
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_BITS = 18
) (
    input  logic            clk,
    input  logic            rst_n,
    seg7_scan_ctrl_if.slave bus
);

    localparam int c_BCD_W = 4 * NUM_DIGITS;
    localparam int c_NIB   = (DATA_W + 3) / 4;
    localparam int c_HEX_W = 4 * ((c_NIB > NUM_DIGITS) ? c_NIB : NUM_DIGITS);
    localparam int c_CNT_W = $clog2(DATA_W);
    localparam int c_IDX_W = $clog2(NUM_DIGITS);
    localparam logic [6:0] c_BLANK = 7'h7F;
    localparam logic [6:0] c_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                          r_state, w_state_next;
    logic                            w_capture, w_commit;
    logic                            r_mode, r_sign, r_ovf_pend, r_overflow;
    logic [DATA_W-1:0]               r_mag;
    logic [c_BCD_W-1:0]              r_bcd, w_bcd_adj;
    logic [c_CNT_W-1:0]              r_cnt;
    logic                            w_in_neg;
    logic [c_HEX_W-1:0]              w_hex_ext;
    logic                            w_hex_hi_nz;
    logic [NUM_DIGITS-1:0][3:0]      w_digit;
    logic                            w_ovf;
    logic [NUM_DIGITS-1:0][6:0]      r_buf, w_buf_new, w_buf_next;
    logic [REFRESH_BITS-1:0]         r_dwell;
    logic [c_IDX_W-1:0]              r_idx, w_idx_next;
    logic [NUM_DIGITS-1:0]           r_an;
    logic [6:0]                      r_seg;

    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'h0: f_glyph = 7'h40;  4'h1: f_glyph = 7'h79;
            4'h2: f_glyph = 7'h24;  4'h3: f_glyph = 7'h30;
            4'h4: f_glyph = 7'h19;  4'h5: f_glyph = 7'h12;
            4'h6: f_glyph = 7'h02;  4'h7: f_glyph = 7'h78;
            4'h8: f_glyph = 7'h00;  4'h9: f_glyph = 7'h10;
            4'hA: f_glyph = 7'h08;  4'hB: f_glyph = 7'h03;
            4'hC: f_glyph = 7'h46;  4'hD: f_glyph = 7'h21;
            4'hE: f_glyph = 7'h06;  default: f_glyph = 7'h0E;
        endcase
    endfunction

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.data_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = bus.display_mode ? S_COMMIT : S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == c_CNT_W'(DATA_W - 1)) w_state_next = S_COMMIT;
            end
            S_COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- conversion datapath ----------------
    assign w_in_neg = bus.is_signed & bus.data[DATA_W-1];

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= 1'b0;
            r_sign     <= 1'b0;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_ovf_pend <= 1'b0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_capture) begin
                r_mode     <= bus.display_mode;
                r_sign     <= w_in_neg;
                r_mag      <= w_in_neg ? -bus.data : bus.data;
                r_bcd      <= '0;
                r_ovf_pend <= 1'b0;
                r_cnt      <= '0;
            end else if (r_state == S_CONV) begin
                r_bcd <= {w_bcd_adj[c_BCD_W-2:0], r_mag[DATA_W-1]};
                r_mag <= {r_mag[DATA_W-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
                if (w_bcd_adj[c_BCD_W-1]) r_ovf_pend <= 1'b1;
            end
            if (w_commit) r_overflow <= w_ovf;
        end
    end

    // ---------------- commit: digit selection, overflow, glyphs ----------------
    // r_mag is left intact in hex mode; in decimal mode it has been shifted out.
    assign w_hex_ext = c_HEX_W'(r_mag);

    generate
        if (c_HEX_W > c_BCD_W) begin : g_hex_hi
            assign w_hex_hi_nz = |w_hex_ext[c_HEX_W-1:c_BCD_W];
        end else begin : g_hex_fits
            assign w_hex_hi_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digit[i] = r_mode ? w_hex_ext[4*i +: 4] : r_bcd[4*i +: 4];
        end
    end

    assign w_ovf = r_ovf_pend | (r_mode & w_hex_hi_nz)
                 | (r_sign & (w_digit[NUM_DIGITS-1] != 4'd0));

`ifdef SEG7_LZ_BLANK_EN
    logic [3:0] w_msd;

    always_comb begin
        w_msd = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_digit[i] != 4'd0) w_msd = 4'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_ovf)                  w_buf_new[i] = c_DASH;
            else if (4'(i) <= w_msd)    w_buf_new[i] = f_glyph(w_digit[i]);
            else if (r_sign && (4'(i) == w_msd + 4'd1)) w_buf_new[i] = c_DASH;
            else                        w_buf_new[i] = c_BLANK;
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_ovf || (r_sign && (i == NUM_DIGITS - 1))) w_buf_new[i] = c_DASH;
            else                                            w_buf_new[i] = f_glyph(w_digit[i]);
        end
    end
`endif

    always_comb begin
        w_buf_next = w_commit ? w_buf_new : r_buf;
    end

    // ---------------- scan ----------------
    // an and seg both derive from the post-edge index and buffer so they never disagree.
    always_comb begin
        w_idx_next = r_idx;
        if (&r_dwell) begin
            w_idx_next = (r_idx == c_IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= {NUM_DIGITS{c_BLANK}};
            r_dwell <= '0;
            r_idx   <= '0;
            r_an    <= '1;
            r_seg   <= c_BLANK;
        end else begin
            r_buf   <= w_buf_next;
            r_dwell <= r_dwell + 1'b1;
            r_idx   <= w_idx_next;
            r_an    <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_idx_next);
            r_seg   <= w_buf_next[w_idx_next];
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.overflow = r_overflow;
    assign bus.seg      = r_seg;
    assign bus.an       = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Three display widths (4/2/3 digits) driven in parallel against a
//            digit-arithmetic reference model; honours SEG7_LZ_BLANK_EN.
// Revision : 1.0
// ============================================================================
module tb_seg7_scan_ctrl;
    localparam int DW = 8;
    localparam int RB = 2;
    localparam logic [6:0] BL = 7'h7F, DASH = 7'h3F;
    localparam logic [6:0] G0 = 7'h40, G2 = 7'h24, G4 = 7'h19, G5 = 7'h12, G8 = 7'h00, G9 = 7'h10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] data = '0;
    logic dv = 1'b0, sg = 1'b0, mode = 1'b0;

    seg7_scan_ctrl_if #(.DATA_W(DW), .NUM_DIGITS(4)) bus4 ();
    seg7_scan_ctrl_if #(.DATA_W(DW), .NUM_DIGITS(2)) bus2 ();
    seg7_scan_ctrl_if #(.DATA_W(DW), .NUM_DIGITS(3)) bus3 ();

    assign bus4.data = data; assign bus4.data_valid = dv; assign bus4.is_signed = sg; assign bus4.display_mode = mode;
    assign bus2.data = data; assign bus2.data_valid = dv; assign bus2.is_signed = sg; assign bus2.display_mode = mode;
    assign bus3.data = data; assign bus3.data_valid = dv; assign bus3.is_signed = sg; assign bus3.display_mode = mode;

    seg7_scan_ctrl #(.DATA_W(DW), .NUM_DIGITS(4), .REFRESH_BITS(RB)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    seg7_scan_ctrl #(.DATA_W(DW), .NUM_DIGITS(2), .REFRESH_BITS(RB)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    seg7_scan_ctrl #(.DATA_W(DW), .NUM_DIGITS(3), .REFRESH_BITS(RB)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    logic [7:0] an_o [3];
    logic [6:0] seg_o [3];
    logic       busy_o [3];
    logic       ovf_o [3];
    assign an_o[0] = {4'hF, bus4.an}; assign seg_o[0] = bus4.seg; assign busy_o[0] = bus4.busy; assign ovf_o[0] = bus4.overflow;
    assign an_o[1] = {6'h3F, bus2.an}; assign seg_o[1] = bus2.seg; assign busy_o[1] = bus2.busy; assign ovf_o[1] = bus2.overflow;
    assign an_o[2] = {5'h1F, bus3.an}; assign seg_o[2] = bus3.seg; assign busy_o[2] = bus3.busy; assign ovf_o[2] = bus3.overflow;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nd_of(input int d);
        case (d)
            0:       nd_of = 4;
            1:       nd_of = 2;
            default: nd_of = 3;
        endcase
    endfunction

    // Conventional active-high segment shapes; the display drives their inverse.
    logic [6:0] lit_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference: plain base-10/16 digit arithmetic on the magnitude.
    function automatic void model_convert(input logic [7:0] v, input bit s, input bit hx, input int nd,
                                          output logic [7:0][6:0] g, output bit ovf);
        bit     neg;
        longint mag, base, lim, t;
        int     dig [8];
        int     msd;
        neg  = s && v[7];
        mag  = neg ? 256 - longint'(v) : longint'(v);
        base = hx ? 16 : 10;
        lim  = 1;
        for (int i = 0; i < nd; i++) lim = lim * base;
        ovf = (mag >= lim);
        t = mag;
        for (int i = 0; i < 8; i++) begin
            dig[i] = int'(t % base);
            t      = t / base;
        end
        if (neg && dig[nd-1] != 0) ovf = 1'b1;
        msd = 0;
        for (int i = 0; i < nd; i++) if (dig[i] != 0) msd = i;
        for (int i = 0; i < 8; i++) g[i] = BL;
        for (int i = 0; i < nd; i++) begin
            if (ovf) g[i] = DASH;
`ifdef SEG7_LZ_BLANK_EN
            else if (i <= msd)                 g[i] = ~lit_hi[dig[i]];
            else if (neg && i == msd + 1)      g[i] = DASH;
            else                               g[i] = BL;
`else
            else if (neg && i == nd - 1)       g[i] = DASH;
            else                               g[i] = ~lit_hi[dig[i]];
`endif
        end
    endfunction

    // ---------------- model state ----------------
    int              n = 0;
    bit              m_busy = 1'b0;
    int              m_commit_at = 0;
    logic [7:0][6:0] m_buf [3];
    logic [7:0][6:0] m_pend [3];
    bit              m_ovf [3];
    bit              m_povf [3];
    logic [7:0][6:0] disp [3];

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_buf[d] = {8{BL}};
            m_ovf[d] = 1'b0;
            disp[d]  = {8{BL}};
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                n      = 0;
                m_busy = 1'b0;
                for (int d = 0; d < 3; d++) begin
                    m_buf[d] = {8{BL}};
                    m_ovf[d] = 1'b0;
                end
            end else begin
                n++;
                if (m_busy) begin
                    if (n == m_commit_at) begin
                        for (int d = 0; d < 3; d++) begin
                            m_buf[d] = m_pend[d];
                            m_ovf[d] = m_povf[d];
                        end
                        m_busy = 1'b0;
                    end
                end else if (dv) begin
                    for (int d = 0; d < 3; d++)
                        model_convert(data, sg, mode, nd_of(d), m_pend[d], m_povf[d]);
                    m_busy      = 1'b1;
                    m_commit_at = n + (mode ? 1 : DW + 1);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            int         idx;
            logic [7:0] exp_an;
            logic [6:0] exp_seg;
            idx     = (n >> RB) % nd_of(d);
            exp_an  = (n == 0) ? 8'hFF : ~(8'd1 << idx);
            exp_seg = (n == 0) ? BL : m_buf[d][idx];
            chk($sformatf("busy[%0d]", d), 32'(busy_o[d]), 32'(m_busy));
            chk($sformatf("ovf[%0d]", d), 32'(ovf_o[d]), 32'(m_ovf[d]));
            chk($sformatf("an[%0d]", d), 32'(an_o[d]), 32'(exp_an));
            chk($sformatf("seg[%0d]", d), 32'(seg_o[d]), 32'(exp_seg));
            for (int i = 0; i < nd_of(d); i++)
                if (an_o[d][i] == 1'b0) disp[d][i] = seg_o[d];
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0][6:0] mk(input logic [6:0] a3, input logic [6:0] a2,
                                           input logic [6:0] a1, input logic [6:0] a0);
        mk = {BL, BL, BL, BL, a3, a2, a1, a0};
    endfunction

    task automatic chk_disp(input string name, input int d, input logic [7:0][6:0] exp);
        for (int i = 0; i < nd_of(d); i++)
            chk($sformatf("%s_dig%0d", name, i), 32'(disp[d][i]), 32'(exp[i]));
    endtask

    task automatic pulse(input logic [7:0] v, input bit s, input bit m);
        @(negedge clk);
        data = v; sg = s; mode = m; dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy_o[0] === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 100) chk("busy_timeout", 32'(busy_o[0]), 32'd0);
    endtask

    task automatic run_conv(input logic [7:0] v, input bit s, input bit m, output int cycles);
        pulse(v, s, m);
        wait_idle(cycles);
    endtask

    task automatic settle();
        repeat (40) @(negedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int bc;
        logic [2:0] an3 [16];
        int cnt101, cnt011;

        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an_o[0]), 32'hFF);
        chk("rst_seg", 32'(seg_o[0]), 32'h7F);
        chk("rst_busy", 32'(busy_o[0]), 32'd0);
        rst_n = 1'b1;

        run_conv(8'd200, 1'b0, 1'b0, bc);
        chk("dec_busy_cycles", bc, 32'd9);
        settle();
`ifdef SEG7_LZ_BLANK_EN
        chk_disp("d200_nd4", 0, mk(BL, G2, G0, G0));
`else
        chk_disp("d200_nd4", 0, mk(G0, G2, G0, G0));
`endif
        chk_disp("d200_nd3", 2, mk(BL, G2, G0, G0));
        chk_disp("d200_nd2", 1, mk(BL, BL, DASH, DASH));
        chk("d200_ovf_nd4", 32'(ovf_o[0]), 32'd0);
        chk("d200_ovf_nd2", 32'(ovf_o[1]), 32'd1);

        run_conv(8'hFB, 1'b1, 1'b0, bc);
        settle();
`ifdef SEG7_LZ_BLANK_EN
        chk_disp("m5_nd4", 0, mk(BL, BL, DASH, G5));
`else
        chk_disp("m5_nd4", 0, mk(DASH, G0, G0, G5));
`endif
        chk_disp("m5_nd2", 1, mk(BL, BL, DASH, G5));

        run_conv(8'h80, 1'b1, 1'b1, bc);
        chk("hex_busy_cycles", bc, 32'd1);
        settle();
`ifdef SEG7_LZ_BLANK_EN
        chk_disp("h80_nd4", 0, mk(BL, DASH, G8, G0));
`else
        chk_disp("h80_nd4", 0, mk(DASH, G0, G8, G0));
`endif
        chk("h80_ovf_nd2", 32'(ovf_o[1]), 32'd1);

        run_conv(8'd42, 1'b0, 1'b0, bc);
        settle();
        chk_disp("d42_nd2", 1, mk(BL, BL, G4, G2));
        chk("d42_ovf_nd2", 32'(ovf_o[1]), 32'd0);

        // A strobe during a conversion must be dropped.
        pulse(8'd99, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        data = 8'd7; dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        wait_idle(bc);
        settle();
`ifdef SEG7_LZ_BLANK_EN
        chk_disp("d99_nd4", 0, mk(BL, BL, G9, G9));
`else
        chk_disp("d99_nd4", 0, mk(G0, G0, G9, G9));
`endif

        // Boundary values, checked by the per-cycle model.
        run_conv(8'h00, 1'b0, 1'b0, bc); settle();
        run_conv(8'h7F, 1'b1, 1'b0, bc); settle();
        run_conv(8'h80, 1'b1, 1'b0, bc); settle();
        run_conv(8'hFF, 1'b1, 1'b1, bc); settle();
        run_conv(8'hFF, 1'b0, 1'b0, bc); settle();
        run_conv(8'h00, 1'b1, 1'b1, bc); settle();

        repeat (1500) begin
            @(negedge clk);
            dv   = ($urandom_range(0, 3) == 0);
            data = 8'($urandom);
            sg   = 1'($urandom_range(0, 1));
            mode = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        dv = 1'b0;
        wait_idle(bc);

        // Asynchronous reset in the middle of a decimal conversion.
        pulse(8'd123, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("async_rst_an[%0d]", d), 32'(an_o[d]), 32'hFF);
            chk($sformatf("async_rst_seg[%0d]", d), 32'(seg_o[d]), 32'h7F);
            chk($sformatf("async_rst_busy[%0d]", d), 32'(busy_o[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j < 16; j++) begin
            @(negedge clk);
            an3[j] = bus3.an;
        end
        chk("scan3_n1", 32'(an3[1]), 32'b110);
        chk("scan3_n4", 32'(an3[4]), 32'b101);
        chk("scan3_n8", 32'(an3[8]), 32'b011);
        chk("scan3_n12", 32'(an3[12]), 32'b110);
        cnt101 = 0;
        cnt011 = 0;
        for (int j = 1; j < 16; j++) begin
            if (an3[j] == 3'b101) cnt101++;
            if (an3[j] == 3'b011) cnt011++;
        end
        chk("scan3_hold_101", cnt101, 32'd4);
        chk("scan3_hold_011", cnt011, 32'd4);
        settle();
        chk_disp("post_rst_nd4", 0, {8{BL}});
        chk("post_rst_ovf", 32'(ovf_o[0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised multi-digit 7-segment controller; successor to the fixed 2-digit/6-bit display path.
- Accepts an N-bit signed or unsigned value with a valid strobe.
- Converts it sequentially: iterative double-dabble for decimal, nibble split for hex.
- Double-buffers the digits and time-multiplexes NUM_DIGITS active-low anodes. Sits between the ALU result register and board pins.

Parameters:
DATA_W, 8, input value width (>=2)
NUM_DIGITS, 4, number of 7-seg digits/anodes (2..8)
REFRESH_BITS, 18, each digit is driven for 2^REFRESH_BITS clk cycles

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data  in  DATA_W  value to display
data_valid  in  1  capture strobe; honoured only when busy=0
is_signed  in  1  1: data is two's complement; 0: unsigned
display_mode  in  1  0 decimal, 1 hex; sampled with data
busy  out  1  conversion in progress
overflow  out  1  committed value did not fit on the display
seg  out  7  segment drive, active-low, {g,f,e,d,c,b,a}
an  out  NUM_DIGITS  anode drive, active-low one-hot, an[0] rightmost

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE, busy=0, overflow=0.
  - Digit buffer all BLANK, scan index 0, dwell counter 0.
  - an all ones, seg=7'h7F. Outputs are registered.
- FSM IDLE -> CONV -> COMMIT -> IDLE.
- IDLE:
  - On data_valid=1 at edge k, latch mode and sign = is_signed & data[DATA_W-1].
  - Latch magnitude = sign ? -data : data, as DATA_W-bit unsigned; the most-negative value maps to 2^(DATA_W-1).
  - busy=1 after edge k.
  - Decimal: go to CONV. Hex: go to COMMIT.
- CONV:
  - One double-dabble step per cycle over a 4*NUM_DIGITS-bit BCD register: add 3 to each nibble >=5, then shift in the magnitude MSB.
  - Runs exactly DATA_W cycles.
  - Any 1 shifted out of the top BCD nibble sets a sticky ovf_pend.
- COMMIT (one cycle):
  - Hex digits = magnitude nibbles; nonzero nibbles beyond NUM_DIGITS set ovf_pend.
  - ovf_pend also set if sign=1 and digit NUM_DIGITS-1 is nonzero, because the sign needs a slot.
  - Copy digits, sign, and overflow to the display buffer. busy=0 after this edge.
  - If overflow: every digit shows dash 7'b0111111.
- Latency, valid to new display content and busy low:
  - Decimal: DATA_W+1 edges, i.e. commit at edge k+DATA_W+1.
  - Hex: 1 edge, i.e. commit at edge k+1.
- data_valid while busy=1 is ignored, with no queueing. The display keeps the old value until commit.
- Sign placement: '-' (7'b0111111) in the leftmost digit (NUM_DIGITS-1). Magnitude digits fill the remaining slots with leading zeros.
- Scan:
  - Dwell counter counts 0..2^REFRESH_BITS-1.
  - On wrap, the scan index increments modulo NUM_DIGITS; the wrap is correct for non-power-of-2 counts.
  - an = ~(1<<index); seg = encoded buffer[index]. Both update on the same edge, so there is no ghost cycle.
- Encoding: hex 0-F glyphs. BLANK = 7'h7F. Decimal digits >9 cannot occur.
- Reset asserted mid-conversion aborts it. The buffer goes blank; no partial commit.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined:
  - Leading zeros are blanked. Digit 0 always shows, so zero displays as "0".
  - Sign '-' moves to the digit immediately left of the most significant displayed digit.
  - Overflow rule is unchanged.
- Undefined: leading zeros displayed; sign fixed in the leftmost digit.

Test Plan (REFRESH_BITS=2 unless stated):
- NUM_DIGITS=4, DATA_W=8, unsigned 8'd200, decimal:
  - busy high for 9 cycles.
  - Digits 3..0 = 0,2,0,0 without LZ; blank,2,0,0 with LZ. overflow=0.
- Signed 8'hFB (-5), decimal:
  - Without LZ: "-005".
  - With LZ: blank,blank,'-',5.
- Signed 8'h80, hex: "-080" without LZ; " -80" with LZ. Commit 1 cycle after valid.
- NUM_DIGITS=2, unsigned 8'd200, decimal: overflow=1, both digits dash. Then 8'd42 gives "42" and overflow=0.
- data_valid pulsed with 8'd7 mid-conversion of 8'd99: ignored; display ends "0099"/"  99". Then rst_n low during a conversion: an=all ones and seg=7'h7F immediately (asynchronous); digits blank afterwards.
- Scan with NUM_DIGITS=3: an sequence 110,101,011,110, each held 4 cycles.
